// File: rtl/adder_pkg.sv
// Shared types and default constants for the adder operand loader.
package adder_pkg;

   localparam int unsigned DEF_DATA_BIT = 64;
   localparam int unsigned DEF_WAIT_MAX = 255;

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      ISSUE  = 2'd2,
      WAIT   = 2'd3
   } state_e;

endpackage

// File: rtl/adder_operand_loader_if.sv
// Byte-stream input, adder handshake and status bundle for the operand loader.
interface adder_operand_loader_if #(
   parameter int unsigned DATA_BIT = adder_pkg::DEF_DATA_BIT
);
   logic [7:0]          in_data;
   logic                in_valid;
   logic                in_ready;
   logic                in_last;
   logic                enable;
   logic [DATA_BIT-1:0] summand;
   logic [DATA_BIT-1:0] addend;
   logic                adder_valid;
   logic                busy;
   logic                frame_error;
   logic                timeout_error;

   // Environment side: feeds bytes and answers as the adder.
   modport master (
      output in_data, in_valid, in_last, adder_valid,
      input  in_ready, enable, summand, addend, busy, frame_error, timeout_error
   );

   // Loader side.
   modport slave (
      input  in_data, in_valid, in_last, adder_valid,
      output in_ready, enable, summand, addend, busy, frame_error, timeout_error
   );
endinterface

// File: rtl/adder_operand_loader.sv
// Assembles two little-endian operands from a byte frame, strobes the adder
// and waits (bounded) for its result-valid.
module adder_operand_loader
   import adder_pkg::*;
#(
   parameter int unsigned DATA_BIT = DEF_DATA_BIT,
   parameter int unsigned WAIT_MAX = DEF_WAIT_MAX
) (
   input logic                   clk,
   input logic                   reset,
   adder_operand_loader_if.slave bus
);

   localparam int unsigned BYTES  = DATA_BIT / 8;
   localparam int unsigned CNT_W  = $clog2(BYTES);
   localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);
   localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES - 1);
   localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(WAIT_MAX - 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [DATA_BIT-1:0] shadow_a_q, shadow_a_d;
   logic [DATA_BIT-1:0] shadow_b_q, shadow_b_d;
   logic [DATA_BIT-1:0] summand_q, summand_d;
   logic [DATA_BIT-1:0] addend_q, addend_d;
   logic                enable_q, enable_d;
   logic                frame_err_q, frame_err_d;
   logic                timeout_q, timeout_d;
   logic                busy_q, busy_d;
   logic                in_ready_q, in_ready_d;
   logic                accept;

   // Next-state, byte assembly and pulse generation.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wait_d      = wait_q;
      shadow_a_d  = shadow_a_q;
      shadow_b_d  = shadow_b_q;
      summand_d   = summand_q;
      addend_d    = addend_q;
      enable_d    = 1'b0;
      frame_err_d = 1'b0;
      timeout_d   = 1'b0;
      accept      = in_ready_q & bus.in_valid;

      unique case (state_q)
         LOAD_A: begin
            if (accept) begin
               shadow_a_d[{cnt_q, 3'b000} +: 8] = bus.in_data;
               if (bus.in_last) begin
                  frame_err_d = 1'b1;
                  cnt_d       = '0;
               end else if (cnt_q == LAST_BYTE) begin
                  state_d = LOAD_B;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         LOAD_B: begin
            if (accept) begin
               shadow_b_d[{cnt_q, 3'b000} +: 8] = bus.in_data;
               if (cnt_q == LAST_BYTE) begin
                  cnt_d = '0;
                  // Only a properly terminated frame reaches the outputs.
                  if (bus.in_last) begin
                     state_d   = ISSUE;
                     enable_d  = 1'b1;
                     summand_d = shadow_a_q;
                     addend_d  = shadow_b_d;
                  end else begin
                     state_d     = LOAD_A;
                     frame_err_d = 1'b1;
                  end
               end else if (bus.in_last) begin
                  state_d     = LOAD_A;
                  cnt_d       = '0;
                  frame_err_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ISSUE: begin
            state_d = WAIT;
            wait_d  = '0;
         end
         WAIT: begin
            // A late result-valid wins over the timeout in the final cycle.
            if (bus.adder_valid) begin
               state_d = LOAD_A;
            end else if (wait_q == LAST_WAIT) begin
               state_d   = LOAD_A;
               timeout_d = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
      endcase

      in_ready_d = (state_d == LOAD_A) || (state_d == LOAD_B);
      busy_d     = !((state_d == LOAD_A) && (cnt_d == '0));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= LOAD_A;
         cnt_q       <= '0;
         wait_q      <= '0;
         shadow_a_q  <= '0;
         shadow_b_q  <= '0;
         summand_q   <= '0;
         addend_q    <= '0;
         enable_q    <= 1'b0;
         frame_err_q <= 1'b0;
         timeout_q   <= 1'b0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wait_q      <= wait_d;
         shadow_a_q  <= shadow_a_d;
         shadow_b_q  <= shadow_b_d;
         summand_q   <= summand_d;
         addend_q    <= addend_d;
         enable_q    <= enable_d;
         frame_err_q <= frame_err_d;
         timeout_q   <= timeout_d;
         busy_q      <= busy_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign bus.in_ready      = in_ready_q;
   assign bus.enable        = enable_q;
   assign bus.summand       = summand_q;
   assign bus.addend        = addend_q;
   assign bus.busy          = busy_q;
   assign bus.frame_error   = frame_err_q;
   assign bus.timeout_error = timeout_q;

endmodule

// File: tb/tb_adder_operand_loader.sv
// Directed plus randomized frames checked against a byte-array operand model.
module tb_adder_operand_loader;
   import adder_pkg::*;

   localparam int DW = 64;
   localparam int NB = DW / 8;
   localparam int WM = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   adder_operand_loader_if #(.DATA_BIT(DW)) bus ();

   adder_operand_loader #(.DATA_BIT(DW), .WAIT_MAX(WM)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0, errors = 0;
   int n_en = 0, n_fe = 0, n_to = 0;
   int exp_en = 0, exp_fe = 0, exp_to = 0;
   logic [7:0]    fb [2*NB];
   logic [DW-1:0] exp_sum = '0, exp_add = '0;

   always @(negedge clk) begin
      if (bus.enable)        n_en++;
      if (bus.frame_error)   n_fe++;
      if (bus.timeout_error) n_to++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=hang expected=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Little-endian operand value of NB bytes starting at fb[base].
   function automatic logic [DW-1:0] operand_of(input int base);
      logic [DW-1:0] v = '0;
      for (int k = 0; k < NB; k++) v = v + (DW'(fb[base+k]) << (8 * k));
      return v;
   endfunction

   // Called at a negedge; returns at the negedge following the transfer.
   task automatic send_byte(input logic [7:0] d, input logic last);
      int guard;
      guard = 0;
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      bus.in_last  = last;
      while (!bus.in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk1("ready_wait", guard < 50, 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   // Full well-formed frame from fb[]; adder answers d cycles into WAIT
   // (d >= WM means never within the window).
   task automatic run_frame(input string tag, input bit gap, input int d, input bit early);
      logic [DW-1:0] prior_sum;
      bit            expect_to;
      prior_sum = exp_sum;
      expect_to = (d >= WM);
      for (int i = 0; i < 2*NB; i++) begin
         send_byte(fb[i], i == 2*NB-1);
         if (i == 0)  chk1($sformatf("%s_busy_loading", tag), bus.busy, 1'b1);
         if (i == NB) chk($sformatf("%s_summand_hold", tag), bus.summand, prior_sum);
         if (i != 2*NB-1) chk1($sformatf("%s_no_early_enable", tag), bus.enable, 1'b0);
         if (gap && i != 2*NB-1) @(negedge clk);
      end
      exp_sum = operand_of(0);
      exp_add = operand_of(NB);
      chk1($sformatf("%s_enable", tag), bus.enable, 1'b1);
      chk($sformatf("%s_summand", tag), bus.summand, exp_sum);
      chk($sformatf("%s_addend", tag), bus.addend, exp_add);
      chk1($sformatf("%s_ready_low", tag), bus.in_ready, 1'b0);
      if (early) bus.adder_valid = 1'b1;
      @(negedge clk);
      bus.adder_valid = 1'b0;
      chk1($sformatf("%s_enable_single", tag), bus.enable, 1'b0);
      for (int i = 0; i <= WM; i++) begin
         bus.adder_valid = (i == d);
         if (i == WM) chk1($sformatf("%s_timeout", tag), bus.timeout_error, expect_to);
         @(negedge clk);
      end
      bus.adder_valid = 1'b0;
      chk1($sformatf("%s_timeout_single", tag), bus.timeout_error, 1'b0);
      chk1($sformatf("%s_idle_busy", tag), bus.busy, 1'b0);
      chk1($sformatf("%s_idle_ready", tag), bus.in_ready, 1'b1);
      exp_en++;
      if (expect_to) exp_to++;
   endtask

   initial begin
      reset           = 1'b1;
      bus.in_data     = '0;
      bus.in_valid    = 1'b0;
      bus.in_last     = 1'b0;
      bus.adder_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_summand", bus.summand, '0);
      chk("rst_addend", bus.addend, '0);
      chk1("rst_enable", bus.enable, 1'b0);
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_frame_error", bus.frame_error, 1'b0);
      chk1("rst_timeout", bus.timeout_error, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      chk1("post_rst_ready", bus.in_ready, 1'b1);

      // Reference frame: 01..08 then 10..17, answered 2 cycles into WAIT.
      for (int i = 0; i < 2*NB; i++) fb[i] = (i < NB) ? 8'(i + 1) : 8'(8'h10 + i - NB);
      run_frame("basic", 1'b0, 2, 1'b0);
      chk("basic_sum_const", bus.summand, 64'h0807060504030201);
      chk("basic_add_const", bus.addend, 64'h1716151413121110);

      run_frame("gapped", 1'b1, 1, 1'b0);
      chk("gapped_sum_const", bus.summand, 64'h0807060504030201);

      // in_last on the fifth byte; adder_valid outside WAIT is ignored.
      bus.adder_valid = 1'b1;
      for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), i == 4);
      chk1("short_frame_error", bus.frame_error, 1'b1);
      chk1("short_no_enable", bus.enable, 1'b0);
      chk1("short_busy", bus.busy, 1'b0);
      chk("short_sum_hold", bus.summand, exp_sum);
      chk("short_add_hold", bus.addend, exp_add);
      @(negedge clk);
      bus.adder_valid = 1'b0;
      chk1("short_fe_single", bus.frame_error, 1'b0);
      exp_fe++;

      // Full-length frame without in_last.
      for (int i = 0; i < 2*NB; i++) send_byte(8'hC0 + 8'(i), 1'b0);
      chk1("nolast_frame_error", bus.frame_error, 1'b1);
      chk1("nolast_no_enable", bus.enable, 1'b0);
      chk("nolast_add_hold", bus.addend, exp_add);
      exp_fe++;
      @(negedge clk);

      // in_last inside the addend half.
      for (int i = 0; i < NB + 4; i++) send_byte(8'h55, i == NB + 3);
      chk1("addend_last_error", bus.frame_error, 1'b1);
      chk1("addend_last_busy", bus.busy, 1'b0);
      exp_fe++;
      @(negedge clk);

      // Wait-window boundaries: last-cycle success, just late, never, early-only.
      for (int i = 0; i < 2*NB; i++) fb[i] = 8'($urandom);
      run_frame("edge_ok", 1'b0, WM - 1, 1'b0);
      for (int i = 0; i < 2*NB; i++) fb[i] = 8'($urandom);
      run_frame("edge_late", 1'b0, WM, 1'b0);
      for (int i = 0; i < 2*NB; i++) fb[i] = 8'($urandom);
      run_frame("no_answer", 1'b0, WM + 1, 1'b0);
      for (int i = 0; i < 2*NB; i++) fb[i] = 8'($urandom);
      run_frame("issue_valid", 1'b0, WM + 1, 1'b1);

      // Reset after ten bytes discards everything.
      for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b0);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_summand", bus.summand, '0);
      chk("midrst_addend", bus.addend, '0);
      chk1("midrst_busy", bus.busy, 1'b0);
      chk1("midrst_enable", bus.enable, 1'b0);
      reset = 1'b0;
      exp_sum = '0;
      exp_add = '0;
      @(negedge clk);
      for (int i = 0; i < 2*NB; i++) fb[i] = 8'($urandom);
      run_frame("post_rst", 1'b0, 0, 1'b0);

      repeat (8) begin
         for (int i = 0; i < 2*NB; i++) fb[i] = 8'($urandom);
         run_frame("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, WM + 1)), 1'b0);
      end

      repeat (3) @(negedge clk);
      chk("enable_count", DW'(n_en), DW'(exp_en));
      chk("frame_error_count", DW'(n_fe), DW'(exp_fe));
      chk("timeout_count", DW'(n_to), DW'(exp_to));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/adder_operand_loader.md
ADDER_OPERAND_LOADER -- requirements
Module: adder_operand_loader

Interface
REQ-001 Parameter DATA_BIT, default 64, operand width in bits; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter WAIT_MAX, default 255, maximum cycles spent waiting for the adder's valid before aborting.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  8  operand byte stream.
REQ-006 in_valid  input  1  in_data holds a byte.
REQ-007 in_ready  output  1  loader accepts a byte this cycle.
REQ-008 in_last  input  1  marks the final byte of a frame.
REQ-009 enable  output  DATA_BIT=n/a, 1  one-cycle start strobe to the downstream adder.
REQ-010 summand  output  DATA_BIT  assembled first operand.
REQ-011 addend  output  DATA_BIT  assembled second operand.
REQ-012 adder_valid  input  1  downstream adder result-valid.
REQ-013 busy  output  1  a frame is in progress or an add is outstanding.
REQ-014 frame_error  output  1  one-cycle pulse when a frame is malformed.
REQ-015 timeout_error  output  1  one-cycle pulse when the adder fails to respond.

Function
REQ-016 A byte SHALL transfer only in a cycle where in_valid and in_ready are both high.
REQ-017 A frame SHALL be 2*BYTES bytes, where BYTES = DATA_BIT/8: first BYTES bytes form summand, next BYTES form addend, little-endian (byte k to bits [8k+7:8k]).
REQ-018 FSM states SHALL be LOAD_A (idle/reset state), LOAD_B, ISSUE, WAIT.
REQ-019 in_ready SHALL be high in LOAD_A and LOAD_B only.
REQ-020 LOAD_A SHALL go to LOAD_B on acceptance of summand byte BYTES-1; LOAD_B SHALL go to ISSUE on acceptance of addend byte BYTES-1; the byte counter SHALL wrap to 0 at each transition.
REQ-021 Bytes SHALL assemble into internal shadow registers; summand/addend outputs SHALL change only on entry to ISSUE and hold otherwise.
REQ-022 in_last accepted on any byte other than addend byte BYTES-1 SHALL pulse frame_error next cycle, discard the partial frame, clear the counter, and return to LOAD_A.
REQ-023 Addend byte BYTES-1 accepted without in_last SHALL pulse frame_error, discard the frame, and return to LOAD_A with no enable.
REQ-024 Latency: last valid byte accepted in cycle N, enable SHALL be high in cycle N+1 only, with new operands valid in the same cycle; WAIT SHALL be entered at N+2.
REQ-025 In WAIT, adder_valid high SHALL return the FSM to LOAD_A next cycle.
REQ-026 In WAIT, a cycle counter SHALL increment each cycle; on reaching WAIT_MAX without adder_valid, timeout_error SHALL pulse and the FSM SHALL return to LOAD_A.
REQ-027 adder_valid in the same cycle the counter reaches WAIT_MAX SHALL be treated as success, with no timeout_error.
REQ-028 adder_valid outside WAIT SHALL be ignored.
REQ-029 busy SHALL be low only in LOAD_A with byte counter 0.

Reset
REQ-030 On reset: state LOAD_A, counters 0, shadow registers 0; summand, addend, enable, in_ready-dependent state, frame_error, timeout_error SHALL be 0.
REQ-031 Reset mid-frame or in WAIT SHALL discard all progress and produce no enable or error pulse.

Structure
REQ-032 Shared package adder_pkg SHALL hold the state enum type and the DATA_BIT and WAIT_MAX default constants.
REQ-033 Block SHALL be a single module; no sub-module is required.

Verification
REQ-034 Bytes 0x01..0x08 then 0x10..0x17 with in_last on byte 16, adder_valid 3 cycles after enable -> summand=0x0807060504030201, addend=0x1716151413121110, one enable pulse, busy low afterwards.
REQ-035 in_valid toggled 0/1 every other cycle for the same frame -> identical operands, enable one cycle after final byte.
REQ-036 in_last on byte 5 -> frame_error single pulse, no enable, summand/addend keep prior values.
REQ-037 Complete frame, adder_valid never asserted, WAIT_MAX=4 -> timeout_error pulse 4 cycles into WAIT, then in_ready high.
REQ-038 Reset asserted after 10 bytes -> all outputs 0, next full frame processes normally.
